// File: rtl/pll_phase_scanner.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : pll_phase_scanner
//  Description : Sweeps the PLL output phase over a programmable range, waits
//                for stable lock at each point, counts data-checker errors
//                over a fixed window and parks the PLL at the best phase.
//  Revision    : 1.0 - initial release
// ============================================================================
module pll_phase_scanner #(
    parameter int HOLDOFF_CYCLES = 32,
    parameter int SETTLE_CYCLES  = 65536,
    parameter int TIMEOUT_CYCLES = 262144,
    parameter int WINDOW_CYCLES  = 4096,
    parameter int ERR_W          = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_i,
    input  logic             clksrc_i,
    input  logic [7:0]       phase_first_i,
    input  logic [7:0]       phase_last_i,
    input  logic [7:0]       phase_stride_i,
    input  logic             pll_locked_i,
    input  logic             sample_err_i,
    output logic             update_o,
    output logic             pll_clksrc_o,
    output logic [7:0]       pll_phase_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [7:0]       best_phase_o,
    output logic [ERR_W-1:0] best_errs_o,
    output logic             scan_fail_o
);

    // The holdoff and measurement phases never overlap, so they share one counter
    localparam int CNT_MAX = (HOLDOFF_CYCLES > WINDOW_CYCLES) ? HOLDOFF_CYCLES : WINDOW_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int STB_W   = $clog2(SETTLE_CYCLES + 1);
    localparam int TMO_W   = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [CNT_W-1:0] HO_LAST  = CNT_W'(HOLDOFF_CYCLES - 1);
    localparam logic [CNT_W-1:0] WIN_LAST = CNT_W'(WINDOW_CYCLES - 1);
    localparam logic [STB_W-1:0] STB_LAST = STB_W'(SETTLE_CYCLES - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [ERR_W-1:0] ERR_MAX  = '1;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ISSUE   = 3'd1,
        ST_HOLDOFF = 3'd2,
        ST_SETTLE  = 3'd3,
        ST_MEASURE = 3'd4,
        ST_NEXT    = 3'd5,
        ST_FINISH  = 3'd6
    } state_t;

    state_t             state_q, state_d;
    logic               clksrc_q, clksrc_d;
    logic [7:0]         last_q, last_d;
    logic [7:0]         stride_q, stride_d;
    logic [7:0]         cur_q, cur_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [STB_W-1:0]   stable_q, stable_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic [ERR_W-1:0]   errs_q, errs_d;
    logic               valid_q, valid_d;
    logic [7:0]         best_phase_q, best_phase_d;
    logic [ERR_W-1:0]   best_errs_q, best_errs_d;
    logic               scan_fail_q, scan_fail_d;
    logic               update_q, update_d;
    logic               pll_clksrc_q, pll_clksrc_d;
    logic [7:0]         pll_phase_q, pll_phase_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    // 9-bit sum so the end-of-range test cannot be fooled by 8-bit wrap
    logic [8:0]         phase_sum;
    logic [ERR_W-1:0]   meas_errs;
    logic               meas_valid;

    assign phase_sum  = {1'b0, cur_q} + {1'b0, stride_q};
    assign meas_errs  = (sample_err_i && (errs_q != ERR_MAX)) ? errs_q + ERR_W'(1) : errs_q;
    assign meas_valid = valid_q & pll_locked_i;

    // State register and all registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            clksrc_q     <= 1'b0;
            last_q       <= '0;
            stride_q     <= '0;
            cur_q        <= '0;
            cnt_q        <= '0;
            stable_q     <= '0;
            tmo_q        <= '0;
            errs_q       <= '0;
            valid_q      <= 1'b0;
            best_phase_q <= '0;
            best_errs_q  <= '0;
            scan_fail_q  <= 1'b0;
            update_q     <= 1'b0;
            pll_clksrc_q <= 1'b0;
            pll_phase_q  <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            clksrc_q     <= clksrc_d;
            last_q       <= last_d;
            stride_q     <= stride_d;
            cur_q        <= cur_d;
            cnt_q        <= cnt_d;
            stable_q     <= stable_d;
            tmo_q        <= tmo_d;
            errs_q       <= errs_d;
            valid_q      <= valid_d;
            best_phase_q <= best_phase_d;
            best_errs_q  <= best_errs_d;
            scan_fail_q  <= scan_fail_d;
            update_q     <= update_d;
            pll_clksrc_q <= pll_clksrc_d;
            pll_phase_q  <= pll_phase_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    // Next-state logic; outputs are derived from the state being entered
    always_comb begin
        state_d      = state_q;
        clksrc_d     = clksrc_q;
        last_d       = last_q;
        stride_d     = stride_q;
        cur_d        = cur_q;
        cnt_d        = cnt_q;
        stable_d     = stable_q;
        tmo_d        = tmo_q;
        errs_d       = errs_q;
        valid_d      = valid_q;
        best_phase_d = best_phase_q;
        best_errs_d  = best_errs_q;
        scan_fail_d  = scan_fail_q;
        pll_clksrc_d = pll_clksrc_q;
        pll_phase_d  = pll_phase_q;

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    clksrc_d     = clksrc_i;
                    last_d       = phase_last_i;
                    stride_d     = (phase_stride_i == 8'd0) ? 8'd1 : phase_stride_i;
                    cur_d        = phase_first_i;
                    best_phase_d = phase_first_i;
                    best_errs_d  = ERR_MAX;
                    scan_fail_d  = 1'b0;
                    state_d      = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                cnt_d   = '0;
                state_d = ST_HOLDOFF;
            end
            ST_HOLDOFF: begin
                // Lock is ignored here: the setter drives areset during this time
                if (cnt_q == HO_LAST) begin
                    stable_d = '0;
                    tmo_d    = '0;
                    state_d  = ST_SETTLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_SETTLE: begin
                stable_d = pll_locked_i ? stable_q + STB_W'(1) : '0;
                tmo_d    = tmo_q + TMO_W'(1);
                if (pll_locked_i && (stable_q == STB_LAST)) begin
                    cnt_d   = '0;
                    errs_d  = '0;
                    valid_d = 1'b1;
                    state_d = ST_MEASURE;
                end else if (tmo_q == TMO_LAST) begin
                    state_d = ST_NEXT;
                end
            end
            ST_MEASURE: begin
                errs_d  = meas_errs;
                valid_d = meas_valid;
                if (cnt_q == WIN_LAST) begin
                    // Strict compare keeps the earliest phase on a tie
                    if (meas_valid && (meas_errs < best_errs_q)) begin
                        best_errs_d  = meas_errs;
                        best_phase_d = cur_q;
                    end
                    state_d = ST_NEXT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_NEXT: begin
                if ((cur_q >= last_q) || (phase_sum > {1'b0, last_q})) begin
                    state_d = ST_FINISH;
                end else begin
                    cur_d   = phase_sum[7:0];
                    state_d = ST_ISSUE;
                end
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        update_d = (state_d == ST_ISSUE) || (state_d == ST_FINISH);
        done_d   = (state_d == ST_FINISH);
        busy_d   = (state_d != ST_IDLE);
        if (state_d == ST_ISSUE) begin
            pll_phase_d  = cur_d;
            pll_clksrc_d = clksrc_d;
        end else if (state_d == ST_FINISH) begin
            pll_phase_d  = best_phase_d;
            pll_clksrc_d = clksrc_q;
            scan_fail_d  = (best_errs_d == ERR_MAX);
        end
    end

    assign update_o     = update_q;
    assign pll_clksrc_o = pll_clksrc_q;
    assign pll_phase_o  = pll_phase_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign best_phase_o = best_phase_q;
    assign best_errs_o  = best_errs_q;
    assign scan_fail_o  = scan_fail_q;

endmodule
`default_nettype wire

// File: tb/tb_pll_phase_scanner.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_pll_phase_scanner
//  Description : Scoreboard bench for pll_phase_scanner. Each scan plans the
//                per-point lock/error behaviour up front, predicts every
//                update pulse and the final result, and a monitor compares
//                them as the DUT emits update pulses.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pll_phase_scanner;

    localparam int H     = 4;
    localparam int S     = 16;
    localparam int T     = 64;
    localparam int W     = 32;
    localparam int EW    = 4;
    localparam int EMAX  = (1 << EW) - 1;
    localparam int LIMIT = 20000;

    // Point behaviours
    localparam int M_GOOD    = 0;
    localparam int M_TIMEOUT = 1;
    localparam int M_DROP    = 2;
    localparam int M_GLITCH  = 3;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start_i = 1'b0;
    logic          clksrc_i = 1'b0;
    logic [7:0]    phase_first_i = '0;
    logic [7:0]    phase_last_i = '0;
    logic [7:0]    phase_stride_i = '0;
    logic          pll_locked_i = 1'b0;
    logic          sample_err_i = 1'b0;
    logic          update_o;
    logic          pll_clksrc_o;
    logic [7:0]    pll_phase_o;
    logic          busy_o;
    logic          done_o;
    logic [7:0]    best_phase_o;
    logic [EW-1:0] best_errs_o;
    logic          scan_fail_o;

    pll_phase_scanner #(
        .HOLDOFF_CYCLES (H),
        .SETTLE_CYCLES  (S),
        .TIMEOUT_CYCLES (T),
        .WINDOW_CYCLES  (W),
        .ERR_W          (EW)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .start_i        (start_i),
        .clksrc_i       (clksrc_i),
        .phase_first_i  (phase_first_i),
        .phase_last_i   (phase_last_i),
        .phase_stride_i (phase_stride_i),
        .pll_locked_i   (pll_locked_i),
        .sample_err_i   (sample_err_i),
        .update_o       (update_o),
        .pll_clksrc_o   (pll_clksrc_o),
        .pll_phase_o    (pll_phase_o),
        .busy_o         (busy_o),
        .done_o         (done_o),
        .best_phase_o   (best_phase_o),
        .best_errs_o    (best_errs_o),
        .scan_fail_o    (scan_fail_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int phase;
        int clksrc;
        int done;
        int bp;
        int be;
        int fail;
    } exp_t;

    exp_t         sb[$];
    exp_t         mon_e;
    int           checks = 0;
    int           errors = 0;

    // Per-point plan: behaviour, its argument, and error strobes inside the window
    int           mode_a[256];
    int           arg_a[256];
    logic [W-1:0] errv_a[256];

    int           drv_pt = 0;
    int           cur_pt = 0;
    int           drv_j = 0;
    bit           drv_active = 1'b0;

    task automatic chk(input string nm, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, expv);
        end
    endtask

    function automatic int sat_count(input logic [W-1:0] v);
        int c;
        c = $countones(v);
        return (c > EMAX) ? EMAX : c;
    endfunction

    function automatic logic [W-1:0] mk_err(input int n);
        logic [W-1:0] v;
        v = '0;
        for (int i = 0; i < n; i++) v[(i * 3) % W] = 1'b1;
        return v;
    endfunction

    task automatic rand_plan(input int p);
        int r;
        r = $urandom_range(0, 9);
        if (r <= 4 || r == 9)  mode_a[p] = M_GOOD;
        else if (r <= 6)       mode_a[p] = M_GLITCH;
        else if (r == 7)       mode_a[p] = M_DROP;
        else                   mode_a[p] = M_TIMEOUT;
        arg_a[p] = (mode_a[p] == M_GLITCH) ? $urandom_range(0, S - 1) : $urandom_range(0, W - 1);
        case ($urandom_range(0, 3))
            0:       errv_a[p] = '0;
            1:       errv_a[p] = W'(1) << $urandom_range(0, W - 1);
            2:       errv_a[p] = W'($urandom & $urandom & $urandom);
            default: errv_a[p] = W'($urandom);
        endcase
    endtask

    // Drives pll_locked/sample_err relative to each point's update pulse.
    // Cycle j=0 is the update cycle; measurement starts after H holdoff
    // cycles plus S consecutive locked cycles.
    initial begin
        int ws;
        bit lk;
        forever begin
            @(posedge clk);
            #1;
            if (update_o && !done_o) begin
                cur_pt = drv_pt;
                drv_pt++;
                drv_j = 0;
                drv_active = 1'b1;
            end else if (update_o && done_o) begin
                drv_active = 1'b0;
            end else begin
                drv_j++;
            end
            lk = 1'($urandom_range(0, 1));
            ws = -100000;
            if (drv_active && drv_j > H) begin
                case (mode_a[cur_pt])
                    M_GOOD:    begin lk = 1'b1; ws = H + S + 1; end
                    M_TIMEOUT: begin lk = 1'b0; end
                    M_DROP:    begin ws = H + S + 1; lk = (drv_j != ws + arg_a[cur_pt]); end
                    default:   begin ws = H + S + 2 + arg_a[cur_pt]; lk = (drv_j != H + 1 + arg_a[cur_pt]); end
                endcase
            end
            pll_locked_i = lk;
            if (drv_active && drv_j >= ws && drv_j < ws + W)
                sample_err_i = errv_a[cur_pt][drv_j - ws];
            else
                sample_err_i = ($urandom_range(0, 3) == 0);
        end
    end

    // Monitor: every update pulse consumes one expected entry
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (!reset) begin
                if (update_o) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_update: got phase %0d expected no pulse", pll_phase_o);
                    end else begin
                        mon_e = sb.pop_front();
                        chk("upd_phase", int'(pll_phase_o), mon_e.phase);
                        chk("upd_clksrc", int'(pll_clksrc_o), mon_e.clksrc);
                        chk("upd_done", int'(done_o), mon_e.done);
                        chk("upd_busy", int'(busy_o), 1);
                        if (mon_e.done != 0) begin
                            chk("best_phase", int'(best_phase_o), mon_e.bp);
                            chk("best_errs", int'(best_errs_o), mon_e.be);
                            chk("scan_fail", int'(scan_fail_o), mon_e.fail);
                        end
                    end
                end else if (done_o) begin
                    chk("done_without_update", int'(done_o), 0);
                end
            end
        end
    end

    task automatic run_scan(input int first, input int last, input int stride, input logic cs,
                            input bit rnd_plan, input int inject_at, input bit same_cycle_start,
                            input int abort_at);
        int   ph[$];
        int   cur, st, bp, be, c, cyc;
        bit   fin, got_done;
        exp_t e;
        st  = (stride == 0) ? 1 : stride;
        cur = first;
        fin = 1'b0;
        while (!fin) begin
            ph.push_back(cur);
            if (cur >= last || cur + st > last) fin = 1'b1;
            else cur = cur + st;
        end
        if (rnd_plan) for (int p = 0; p < ph.size(); p++) rand_plan(p);
        be = EMAX;
        bp = first;
        for (int p = 0; p < ph.size(); p++) begin
            if (mode_a[p] == M_GOOD || mode_a[p] == M_GLITCH) begin
                c = sat_count(errv_a[p]);
                if (c < be) begin
                    be = c;
                    bp = ph[p];
                end
            end
        end
        for (int p = 0; p < ph.size(); p++) begin
            e = '{phase: ph[p], clksrc: int'(cs), done: 0, bp: 0, be: 0, fail: 0};
            sb.push_back(e);
        end
        e = '{phase: bp, clksrc: int'(cs), done: 1, bp: bp, be: be, fail: int'(be == EMAX)};
        sb.push_back(e);

        drv_pt = 0;
        @(posedge clk);
        #1;
        phase_first_i  = 8'(first);
        phase_last_i   = 8'(last);
        phase_stride_i = 8'(stride);
        clksrc_i       = cs;
        start_i        = 1'b1;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        chk("busy_after_start", int'(busy_o), 1);
        phase_first_i  = 8'($urandom);
        phase_last_i   = 8'($urandom);
        phase_stride_i = 8'($urandom);
        clksrc_i       = ~cs;

        got_done = 1'b0;
        cyc = 0;
        while (cyc < LIMIT && !got_done) begin
            @(posedge clk);
            #1;
            cyc++;
            if (done_o) begin
                got_done = 1'b1;
            end else begin
                start_i = (cyc == inject_at);
                if (cyc == abort_at) begin
                    #2;
                    reset = 1'b1;
                    #1;
                    chk("abort_update", int'(update_o), 0);
                    chk("abort_busy", int'(busy_o), 0);
                    chk("abort_done", int'(done_o), 0);
                    chk("abort_best_errs", int'(best_errs_o), 0);
                    sb.delete();
                    start_i = 1'b0;
                    @(posedge clk);
                    #1;
                    reset = 1'b0;
                    return;
                end
            end
        end
        if (!got_done) begin
            checks++;
            errors++;
            $display("FAIL scan_timeout: got no done after %0d cycles expected done", LIMIT);
        end
        start_i = same_cycle_start;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        chk("idle_after_done", int'(busy_o), 0);
        chk("done_one_cycle", int'(done_o), 0);
        @(posedge clk);
        #1;
        chk("idle_stays", int'(busy_o), 0);
        chk("sb_empty", sb.size(), 0);
        sb.delete();
    endtask

    task automatic set_good(input int n);
        for (int p = 0; p < n; p++) begin
            mode_a[p] = M_GOOD;
            arg_a[p]  = 0;
            errv_a[p] = '0;
        end
    endtask

    initial begin
        int f, l, s;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_update", int'(update_o), 0);
        chk("rst_busy", int'(busy_o), 0);
        chk("rst_done", int'(done_o), 0);
        chk("rst_phase", int'(pll_phase_o), 0);
        chk("rst_clksrc", int'(pll_clksrc_o), 0);
        chk("rst_best_phase", int'(best_phase_o), 0);
        chk("rst_best_errs", int'(best_errs_o), 0);
        chk("rst_scan_fail", int'(scan_fail_o), 0);
        reset = 1'b0;
        repeat (2) @(posedge clk);

        // Clean sweep 0,4,8 with no errors
        set_good(3);
        run_scan(0, 8, 4, 1'b1, 1'b0, -1, 1'b0, -1);

        // Errors 5/2/2: tie keeps phase 4
        set_good(3);
        errv_a[0] = mk_err(5);
        errv_a[1] = mk_err(2);
        errv_a[2] = mk_err(2);
        run_scan(0, 8, 4, 1'b0, 1'b0, -1, 1'b0, -1);

        // Lock never arrives: every point times out
        for (int p = 0; p < 3; p++) begin
            mode_a[p] = M_TIMEOUT;
            errv_a[p] = '0;
        end
        run_scan(0, 8, 4, 1'b0, 1'b0, -1, 1'b0, -1);

        // Range edges and stride 0
        run_scan(250, 255, 10, 1'b1, 1'b1, -1, 1'b0, -1);
        run_scan(3, 5, 0, 1'b0, 1'b1, -1, 1'b0, -1);
        run_scan(9, 3, 2, 1'b1, 1'b1, -1, 1'b0, -1);
        run_scan(250, 255, 5, 1'b0, 1'b1, -1, 1'b0, -1);

        // Lock lost inside the window at phase 4; start pulses mid-scan and on done
        set_good(3);
        mode_a[1] = M_DROP;
        arg_a[1]  = 10;
        errv_a[0] = mk_err(3);
        errv_a[2] = mk_err(1);
        run_scan(0, 8, 4, 1'b1, 1'b0, 40, 1'b1, -1);

        // Saturated counts never beat the all-ones initial best
        set_good(3);
        errv_a[0] = mk_err(20);
        errv_a[1] = mk_err(15);
        errv_a[2] = mk_err(16);
        run_scan(10, 12, 1, 1'b1, 1'b0, -1, 1'b0, -1);

        // Reset during a measurement window, then during an update pulse
        set_good(3);
        run_scan(0, 8, 4, 1'b1, 1'b0, -1, 1'b0, 30);
        set_good(3);
        run_scan(0, 8, 4, 1'b1, 1'b0, -1, 1'b0, 54);
        set_good(3);
        errv_a[0] = mk_err(4);
        errv_a[2] = mk_err(7);
        run_scan(0, 8, 4, 1'b0, 1'b0, -1, 1'b0, -1);

        // Randomised scans
        for (int k = 0; k < 20; k++) begin
            f = $urandom_range(0, 255);
            if ($urandom_range(0, 4) == 0) begin
                l = $urandom_range(0, 255);
                s = $urandom_range(20, 255);
            end else begin
                l = f + $urandom_range(0, 20);
                if (l > 255) l = 255;
                s = $urandom_range(0, 6);
            end
            run_scan(f, l, s, 1'($urandom_range(0, 1)), 1'b1,
                     ($urandom_range(0, 1) == 1) ? $urandom_range(5, 200) : -1,
                     1'($urandom_range(0, 1)), -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
